// File: rtl/uart_baud_pkg.sv
// Shared definitions for the runtime UART baud-rate controller:
// clock/oversample defaults, supported-rate table, divider lookup,
// response codes and the controller FSM state type.
package uart_baud_pkg;

  localparam int unsigned DEF_CLK_FREQ   = 50_000_000;
  localparam int unsigned DEF_OVERSAMPLE = 16;

  localparam int NUM_RATES = 13;

  localparam logic [31:0] BAUD_RATES [NUM_RATES] = '{
    32'd300,    32'd600,    32'd1200,   32'd2400,   32'd4800,
    32'd9600,   32'd19200,  32'd38400,  32'd57600,  32'd115200,
    32'd230400, 32'd460800, 32'd921600
  };

  // Marker returned by the lookup for a rate outside the table.
  localparam logic [31:0] DIV_INVALID = 32'hFFFF_FFFF;

  localparam logic [1:0] RSP_OK      = 2'd0;
  localparam logic [1:0] RSP_BADRATE = 2'd1;
  localparam logic [1:0] RSP_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DRAIN = 2'd2,
    APPLY = 2'd3
  } state_t;

  // Divider for an arbitrary clock/oversample pair. Every term is a
  // compile-time constant per table entry, so this folds to a compare/mux.
  function automatic logic [31:0] baud_to_div_cfg(input logic [31:0] rate,
                                                   input int unsigned clk_freq,
                                                   input int unsigned oversample);
    logic [31:0] div;
    div = DIV_INVALID;
    for (int i = 0; i < NUM_RATES; i++) begin
      if (rate == BAUD_RATES[i]) begin
        div = clk_freq / (oversample * BAUD_RATES[i]) - 32'd1;
      end
    end
    return div;
  endfunction

  // Divider at the package default clock and oversample ratio.
  function automatic logic [31:0] baud_to_div(input logic [31:0] rate);
    return baud_to_div_cfg(rate, DEF_CLK_FREQ, DEF_OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_ctrl_if.sv
// Request/response channel between the settings logic (master) and the
// baud-rate controller (slave).
//
// Handshake: a request transfers on a rising clock edge where both
// req_valid and req_ready are high; req_baud must be stable while
// req_valid is high. There is no backpressure on the response: rsp_valid
// is a single-cycle pulse and rsp_code is only meaningful while it is high.
interface uart_baud_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_baud;
  logic        rsp_valid;
  logic [1:0]  rsp_code;

  modport master (
    output req_valid,
    output req_baud,
    input  req_ready,
    input  rsp_valid,
    input  rsp_code
  );

  modport slave (
    input  req_valid,
    input  req_baud,
    output req_ready,
    output rsp_valid,
    output rsp_code
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Holds the active divider and produces the oversample tick: a counter
// runs 0..divider, tick is high while count == divider, and a load
// replaces the divider and restarts the counter from zero.
module baud_tick_gen #(
  parameter logic [31:0] RESET_DIV = 32'd26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_div,
  output logic [31:0] divider,
  output logic        tick
);

  logic [31:0] div_q, div_d;
  logic [31:0] cnt_q, cnt_d;

  assign tick    = (cnt_q == div_q);
  assign divider = div_q;

  // Next divider/count: wrap after the tick cycle, restart on load.
  always_comb begin
    div_d = div_q;
    cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
    if (load) begin
      div_d = load_div;
      cnt_d = 32'd0;
    end
  end

  // Divider and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= RESET_DIV;
      cnt_q <= 32'd0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_baud_ctrl.sv
// Runtime baud-rate controller. Accepts one request at a time, rejects
// rates outside the supported table, waits for the UART to go idle and
// then loads the new divider and restarts the oversample tick.
// Optional build macro: UART_BAUD_DRAIN_TIMEOUT_EN bounds the idle wait
// to DRAIN_TIMEOUT cycles and reports such an apply with RSP_TIMEOUT.
module uart_baud_ctrl
  import uart_baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = DEF_CLK_FREQ,
  parameter int unsigned OVERSAMPLE    = DEF_OVERSAMPLE,
  parameter logic [31:0] DEFAULT_BAUD  = 32'd115200,
  parameter int unsigned DRAIN_TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  uart_baud_ctrl_if.slave   req_if,
  input  logic              uart_busy,
  output logic [31:0]       cfg_divider,
  output logic              cfg_load,
  output logic              tick,
  output logic [31:0]       cur_baud,
  output state_t            dbg_state
);

  localparam logic [31:0] RESET_DIV = baud_to_div_cfg(DEFAULT_BAUD, CLK_FREQ, OVERSAMPLE);

  if (DRAIN_TIMEOUT == 0) begin : g_bad_timeout
    $error("DRAIN_TIMEOUT must be at least 1");
  end

  state_t      state_q, state_d;
  logic [31:0] baud_q, baud_d;          // rate captured at the handshake
  logic [31:0] div_q, div_d;            // registered lookup result
  logic [31:0] cur_baud_q, cur_baud_d;
  logic        cfg_load_q, cfg_load_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_code_q, rsp_code_d;
  logic [31:0] lookup_div;
  logic        apply_load;              // high on the edge entering APPLY

`ifdef UART_BAUD_DRAIN_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(DRAIN_TIMEOUT - 1);
  logic [31:0] drain_cnt_q, drain_cnt_d;
`endif

  assign lookup_div       = baud_to_div_cfg(baud_q, CLK_FREQ, OVERSAMPLE);
  assign req_if.req_ready = (state_q == IDLE);
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_code  = rsp_code_q;
  assign cfg_load         = cfg_load_q;
  assign cur_baud         = cur_baud_q;
  assign dbg_state        = state_q;

  // Next-state and registered-output logic for the request sequence.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    div_d       = div_q;
    cur_baud_d  = cur_baud_q;
    cfg_load_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_code_d  = rsp_code_q;
    apply_load  = 1'b0;
`ifdef UART_BAUD_DRAIN_TIMEOUT_EN
    drain_cnt_d = drain_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_if.req_valid) begin
          baud_d  = req_if.req_baud;
          state_d = CHECK;
        end
      end
      CHECK: begin
        div_d = lookup_div;
`ifdef UART_BAUD_DRAIN_TIMEOUT_EN
        drain_cnt_d = 32'd0;
`endif
        if (lookup_div == DIV_INVALID) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_code_d  = RSP_BADRATE;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
`ifdef UART_BAUD_DRAIN_TIMEOUT_EN
        drain_cnt_d = drain_cnt_q + 32'd1;
        if (!uart_busy) begin
          apply_load = 1'b1;
          rsp_code_d = RSP_OK;
        end else if (drain_cnt_q == TIMEOUT_LAST) begin
          apply_load = 1'b1;
          rsp_code_d = RSP_TIMEOUT;
        end
`else
        if (!uart_busy) begin
          apply_load = 1'b1;
          rsp_code_d = RSP_OK;
        end
`endif
        if (apply_load) begin
          state_d     = APPLY;
          cur_baud_d  = baud_q;
          cfg_load_d  = 1'b1;
          rsp_valid_d = 1'b1;
        end
      end
      APPLY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      baud_q      <= DEFAULT_BAUD;
      div_q       <= RESET_DIV;
      cur_baud_q  <= DEFAULT_BAUD;
      cfg_load_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= RSP_OK;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      div_q       <= div_d;
      cur_baud_q  <= cur_baud_d;
      cfg_load_q  <= cfg_load_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
    end
  end

`ifdef UART_BAUD_DRAIN_TIMEOUT_EN
  // Cycles spent waiting for the UART to drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_cnt_q <= 32'd0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
    end
  end
`endif

  baud_tick_gen #(
    .RESET_DIV (RESET_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (apply_load),
    .load_div (div_q),
    .divider  (cfg_divider),
    .tick     (tick)
  );

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl at 50 MHz / 16x oversample.
module tb_uart_baud_ctrl;
  import uart_baud_pkg::*;

`ifdef UART_BAUD_DRAIN_TIMEOUT_EN
  localparam int BUSY_HOLD = 50;
`else
  localparam int BUSY_HOLD = 500;
`endif
  localparam int TICK_LIMIT = 20000;

  logic        clk;
  logic        reset;
  logic        uart_busy;
  logic [31:0] cfg_divider;
  logic        cfg_load;
  logic        tick;
  logic [31:0] cur_baud;
  state_t      dbg_state;

  int n_tests;
  int n_fail;

  uart_baud_ctrl_if bus ();

  uart_baud_ctrl #(
    .CLK_FREQ      (50_000_000),
    .OVERSAMPLE    (16),
    .DEFAULT_BAUD  (32'd115200),
    .DRAIN_TIMEOUT (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_if      (bus.slave),
    .uart_busy   (uart_busy),
    .cfg_divider (cfg_divider),
    .cfg_load    (cfg_load),
    .tick        (tick),
    .cur_baud    (cur_baud),
    .dbg_state   (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock; outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // edges until the next cycle with tick high (bounded)
  task automatic count_to_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < TICK_LIMIT);
  endtask

  // present a request in the current cycle; returns one cycle later
  task automatic send_req(input logic [31:0] baud);
    bus.req_valid = 1'b1;
    bus.req_baud  = baud;
    chk("req_ready_at_handshake", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    bus.req_baud  = 32'd0;
  endtask

  initial begin
    int n;
    int bad;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    uart_busy = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_baud  = 32'd0;

    // reset, then idle
    step(); step(); step();
    reset = 1'b0;
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_div", cfg_divider, 32'd26);
    chk("rst_baud", cur_baud, 32'd115200);
    chk("rst_load", 32'(cfg_load), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_code", 32'(bus.rsp_code), 32'd0);
    count_to_tick(n);
    chk("rst_first_tick", n, 26);
    count_to_tick(n);
    chk("rst_tick_period", n, 27);

    // 9600 with idle UART
    send_req(32'd9600);
    chk("v_t1_state", 32'(dbg_state), 32'(CHECK));
    chk("v_t1_ready", 32'(bus.req_ready), 32'd0);
    chk("v_t1_rsp", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("v_t2_state", 32'(dbg_state), 32'(DRAIN));
    chk("v_t2_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("v_t2_div_old", cfg_divider, 32'd26);
    step();
    chk("v_t3_state", 32'(dbg_state), 32'(APPLY));
    chk("v_t3_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("v_t3_code", 32'(bus.rsp_code), 32'(RSP_OK));
    chk("v_t3_load", 32'(cfg_load), 32'd1);
    chk("v_t3_div", cfg_divider, 32'd324);
    chk("v_t3_baud", cur_baud, 32'd9600);
    step();
    chk("v_t4_ready", 32'(bus.req_ready), 32'd1);
    chk("v_t4_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("v_t4_load", 32'(cfg_load), 32'd0);
    count_to_tick(n);
    chk("v_first_tick", n, 323);
    count_to_tick(n);
    chk("v_tick_period", n, 325);

    // invalid rate issued on a tick cycle: phase must be undisturbed
    send_req(32'd12345);
    chk("bad_t1_rsp", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("bad_t2_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("bad_t2_code", 32'(bus.rsp_code), 32'(RSP_BADRATE));
    chk("bad_t2_state", 32'(dbg_state), 32'(IDLE));
    chk("bad_t2_ready", 32'(bus.req_ready), 32'd1);
    chk("bad_t2_load", 32'(cfg_load), 32'd0);
    chk("bad_div", cfg_divider, 32'd324);
    chk("bad_baud", cur_baud, 32'd9600);
    count_to_tick(n);
    chk("bad_tick_phase", n, 323);

    // 300 while the UART stays busy
    uart_busy = 1'b1;
    send_req(32'd300);
    step();
    chk("busy_drain", 32'(dbg_state), 32'(DRAIN));
    bad = 0;
    for (int i = 0; i < BUSY_HOLD; i++) begin
      step();
      if (cfg_load || bus.rsp_valid || dbg_state != DRAIN || bus.req_ready) bad++;
    end
    chk("busy_no_load", bad, 0);
    chk("busy_div_held", cfg_divider, 32'd324);
    uart_busy = 1'b0;
    step();
    chk("busy_apply_state", 32'(dbg_state), 32'(APPLY));
    chk("busy_apply_load", 32'(cfg_load), 32'd1);
    chk("busy_apply_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("busy_apply_code", 32'(bus.rsp_code), 32'(RSP_OK));
    chk("busy_div", cfg_divider, 32'd10415);
    chk("busy_baud", cur_baud, 32'd300);
    step();

    // reset in DRAIN aborts silently
    uart_busy = 1'b1;
    send_req(32'd19200);
    step();
    chk("abort_in_drain", 32'(dbg_state), 32'(DRAIN));
    reset = 1'b1;
    step();
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    chk("abort_div", cfg_divider, 32'd26);
    chk("abort_baud", cur_baud, 32'd115200);
    chk("abort_rsp", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b0;
    uart_busy = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.rsp_valid || cfg_load) bad++;
    end
    chk("abort_no_rsp", bad, 0);
    chk("abort_div_kept", cfg_divider, 32'd26);

    // fresh 921600 request
    send_req(32'd921600);
    step();
    step();
    chk("fast_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("fast_code", 32'(bus.rsp_code), 32'(RSP_OK));
    chk("fast_div", cfg_divider, 32'd2);
    chk("fast_baud", cur_baud, 32'd921600);
    count_to_tick(n);
    chk("fast_first_tick", n, 2);
    count_to_tick(n);
    chk("fast_tick_period", n, 3);

    // same rate again from a tick cycle: APPLY lands where a tick was due
    send_req(32'd921600);
    step();
    step();
    chk("same_apply_load", 32'(cfg_load), 32'd1);
    chk("same_apply_tick", 32'(tick), 32'd0);
    count_to_tick(n);
    chk("same_restart_tick", n, 2);

`ifdef UART_BAUD_DRAIN_TIMEOUT_EN
    // drain timeout after 100 busy cycles
    step();
    uart_busy = 1'b1;
    send_req(32'd4800);
    step();
    bad = 0;
    for (int i = 0; i < 99; i++) begin
      if (dbg_state != DRAIN || bus.rsp_valid) bad++;
      step();
    end
    chk("to_wait", bad, 0);
    chk("to_last_drain", 32'(dbg_state), 32'(DRAIN));
    step();
    chk("to_apply", 32'(dbg_state), 32'(APPLY));
    chk("to_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("to_code", 32'(bus.rsp_code), 32'(RSP_TIMEOUT));
    chk("to_div", cfg_divider, 32'd650);
    uart_busy = 1'b0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

Runtime baud-rate controller for the terminal UART. It accepts baud-change requests over a valid/ready handshake and rejects unsupported rates. For a supported rate it waits for the UART to go idle, then loads the new divider and restarts the 16x oversample tick. It sits between the settings/OSD logic and the UART core, and it is the only driver of the UART's divider and tick enable.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `OVERSAMPLE`, 16, ticks per bit.
- `DEFAULT_BAUD`, 115200, rate loaded at reset.
- `DRAIN_TIMEOUT`, 1_000_000, maximum drain wait in cycles (used only with the macro).

Ports:
- `clk` in 1: system clock. One clock domain; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_baud` in 32: requested rate in baud.
- `uart_busy` in 1: UART TX or RX frame in progress.
- `cfg_divider` out 32: active divider.
- `cfg_load` out 1: one-cycle pulse when a new divider takes effect.
- `tick` out 1: oversample enable pulse.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_code` out 2: 0 = OK, 1 = invalid rate, 2 = applied by timeout.
- `cur_baud` out 32: active rate.

## Operation
- Supported rates: 300, 600, 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600.
- Divider formula: div = CLK_FREQ/(OVERSAMPLE*rate) − 1, using integer division with truncation.
- Any other rate is invalid.
- FSM states: IDLE, CHECK, DRAIN, APPLY.
  - IDLE: `req_ready`=1. On handshake, capture `req_baud` and go to CHECK.
  - CHECK: register the lookup result. If invalid, return to IDLE with rsp_valid=1 and rsp_code=1 on that transition. If valid, go to DRAIN.
  - DRAIN: stay while `uart_busy`=1. When `uart_busy`=0, go to APPLY.
  - APPLY: write the new `cfg_divider`/`cur_baud` on the edge entering APPLY. During the APPLY cycle assert cfg_load=1, rsp_valid=1, rsp_code=0. Then return to IDLE.
- Requests are not queued; `req_ready`=0 outside IDLE.
- A request for the already-active rate still runs the full sequence and restarts the tick phase.
- Tick generator:
  - A counter runs from 0 to `cfg_divider`.
  - `tick`=1 in the cycle where count == `cfg_divider`, and the counter wraps to 0 on the next edge. Tick period = div+1 cycles.
  - The counter clears to 0 on the edge entering APPLY.
- `uart_busy` is ignored outside DRAIN.

## Timing
- Reset values:
  - state IDLE.
  - `cfg_divider` = div(DEFAULT_BAUD), which is 26 at the defaults.
  - `cur_baud` = DEFAULT_BAUD.
  - tick counter = 0.
  - `cfg_load`, `tick`, `rsp_valid` = 0; `rsp_code` = 0.
  - `req_ready` = 1 in the first cycle after reset.
- Request timing, with the handshake at cycle T:
  - Invalid rate: CHECK at T+1, rsp pulse at T+2 with the FSM back in IDLE, `req_ready` high at T+2.
  - Valid rate with idle UART: DRAIN at T+2, APPLY at T+3, `req_ready` high at T+4.
- Minimum handshake-to-response latency is 3 cycles. DRAIN extends it by every cycle `uart_busy` remains high.
- After APPLY at cycle A, the first `tick` occurs at cycle A+div.
- Reset asserted in any state aborts the operation. No rsp pulse is issued, and all reset values apply on the next edge.

## Configuration
- Macro `UART_BAUD_DRAIN_TIMEOUT_EN` defined:
  - A drain counter clears on entry to DRAIN.
  - If `uart_busy` is still high after DRAIN_TIMEOUT cycles in DRAIN, the FSM goes to APPLY anyway and reports rsp_code=2.
- Macro undefined:
  - DRAIN waits indefinitely.
  - rsp_code=2 is never produced, and no counter logic exists.

## Structure
- Package `uart_baud_pkg` holds:
  - CLK_FREQ and OVERSAMPLE defaults;
  - the supported-rate list;
  - function `baud_to_div(rate)`, which returns 32'hFFFF_FFFF for an invalid rate;
  - rsp_code constants RSP_OK, RSP_BADRATE, RSP_TIMEOUT;
  - the FSM state enum.
- One sub-module, `baud_tick_gen`: the divider register, the tick counter with synchronous clear on load, and the `tick` output.

## Test plan
- Reset, then no requests: `cfg_divider`=26, `cur_baud`=115200, and `tick` every 27 cycles, first tick 26 cycles after reset deasserts.
- Request 9600 with `uart_busy`=0:
  - rsp_valid with code 0 three cycles after the handshake;
  - `cfg_load` pulse in the same cycle;
  - `cfg_divider`=324 and tick period 325.
- Request 12345: rsp_code=1 two cycles after the handshake; `cfg_divider` and tick phase unchanged.
- Request 300 while `uart_busy` is held high for 500 cycles: no load until busy falls; APPLY 1 cycle after the fall; `cfg_divider`=10415.
- Assert `reset` during DRAIN: no rsp pulse, defaults restored, and a fresh 921600 request then yields `cfg_divider`=2.
- With `UART_BAUD_DRAIN_TIMEOUT_EN` and DRAIN_TIMEOUT=100, hold busy high: apply occurs after 100 DRAIN cycles with rsp_code=2.
